sd_block_scanner: RTL and testbench
===================================

SD_BLOCK_SCANNER -- requirements
Module: sd_block_scanner

Interface
REQ-001 Parameter BASE_ADDR, default 32'd8192, first SD block address scanned.
REQ-002 Parameter MAX_BLOCKS, default 1024, blocks scanned before giving up (range 1..65535).
REQ-003 Parameter SIG, default 64'h444C41425F544142 ("DLAB_TAB"), signature; byte 0 = SIG[63:56].
REQ-004 Parameter TIMEOUT, default 20'd1000000, idle cycles allowed in READ between out_valid pulses.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle scan request.
REQ-008 abort  input  1  cancel an active scan.
REQ-009 init_finish  input  1  SD controller initialised.
REQ-010 rd_req  output  1  block read request to SD controller.
REQ-011 block_address  output  32  block address to SD controller.
REQ-012 dout  input  8  SD data byte.
REQ-013 out_valid  input  1  dout valid, one byte per cycle.
REQ-014 buf_we  output  1  buffer write enable.
REQ-015 buf_addr  output  9  buffer byte address.
REQ-016 buf_wdata  output  8  buffer write data.
REQ-017 busy  output  1  scan in progress.
REQ-018 done  output  1  one-cycle end-of-scan pulse.
REQ-019 found  output  1  signature matched in last scan.
REQ-020 err  output  1  last scan timed out.
REQ-021 match_addr  output  32  block address of match.
REQ-022 blocks_scanned  output  16  blocks fully read in current/last scan.

Function
REQ-023 States SHALL be IDLE, WAIT_INIT, REQ, READ, CHECK, DONE.
REQ-024 IDLE: start=1 -> WAIT_INIT; clear found, err, match_addr, blocks_scanned; block_address <= BASE_ADDR.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 WAIT_INIT: init_finish=1 -> REQ; else stay (no timeout).
REQ-027 REQ: rd_req=1 for exactly this one cycle; byte_cnt <= 0, sig_ok <= 1, timer <= 0; -> READ.
REQ-028 rd_req SHALL be 0 in every state other than REQ.
REQ-029 READ: buf_we = out_valid (combinational), buf_addr = byte_cnt[8:0], buf_wdata = dout.
REQ-030 READ, out_valid=1: byte_cnt +1 (10-bit); if byte_cnt<8 and dout != SIG byte[byte_cnt], sig_ok <= 0; timer <= 0.
REQ-031 READ, out_valid=0: timer +1; timer == TIMEOUT-1 -> DONE with err <= 1, found <= 0.
REQ-032 READ: byte_cnt == 512 -> CHECK; blocks_scanned +1 on that transition.
REQ-033 out_valid outside READ SHALL be ignored: buf_we=0, no counter change.
REQ-034 CHECK: sig_ok=1 -> DONE, found <= 1, match_addr <= block_address.
REQ-035 CHECK: sig_ok=0 and blocks_scanned == MAX_BLOCKS -> DONE, found <= 0.
REQ-036 CHECK: otherwise block_address <= block_address + 1 (mod 2^32, wraps FFFFFFFF->0) -> REQ.
REQ-037 DONE: done=1 for this one cycle -> IDLE; found, err, match_addr, blocks_scanned held until next accepted start.
REQ-038 busy=1 in all states except IDLE.
REQ-039 abort=1 in WAIT_INIT/REQ/READ/CHECK -> IDLE next cycle; no done pulse; found=0, err=0; abort has priority over all other transitions.
REQ-040 abort in IDLE or DONE SHALL have no effect.
REQ-041 Bytes beyond 512 in one block cannot occur (CHECK entered at 512); buf_addr never exceeds 511.

Reset
REQ-042 reset SHALL dominate abort and start.
REQ-043 On reset: state IDLE, rd_req=0, block_address=BASE_ADDR, busy=0, done=0, found=0, err=0, match_addr=0, blocks_scanned=0, byte_cnt=0, timer=0.
REQ-044 Reset mid-scan SHALL take effect next edge with no done pulse and no further buf_we.

Verification
REQ-045 init_finish=1, start; signature in block 8194 -> rd_req pulses for 8192, 8193, 8194; done with found=1, match_addr=8194, blocks_scanned=3.
REQ-046 MAX_BLOCKS=4, no signature -> four rd_req pulses, done with found=0, err=0, blocks_scanned=4, block_address=8195.
REQ-047 init_finish=0 then start; raise init_finish 50 cycles later -> rd_req exactly one cycle after init_finish seen; busy=1 throughout.
REQ-048 TIMEOUT=100, SD stalls after byte 200 -> done 100 cycles after last out_valid, err=1, found=0, buf_addr max 199.
REQ-049 abort at byte 300 of block 2 -> IDLE next cycle, no done, busy=0; subsequent start restarts at 8192 with blocks_scanned=0.
REQ-050 BASE_ADDR=32'hFFFFFFFF, MAX_BLOCKS=2 -> second rd_req has block_address=0; start during busy and out_valid in IDLE produce no effect.

Source files
------------

// File: rtl/sd_block_scanner.sv
// Scans consecutive SD blocks from BASE_ADDR for an 8-byte signature at the
// start of a block, mirroring every received byte into a 512-byte buffer.
module sd_block_scanner #(
  parameter logic [31:0] BASE_ADDR  = 32'd8192,
  parameter int          MAX_BLOCKS = 1024,
  parameter logic [63:0] SIG        = 64'h444C41425F544142,
  parameter logic [19:0] TIMEOUT    = 20'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        init_finish,
  output logic        rd_req,
  output logic [31:0] block_address,
  input  logic [7:0]  dout,
  input  logic        out_valid,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        err,
  output logic [31:0] match_addr,
  output logic [15:0] blocks_scanned
);

  typedef enum logic [2:0] {IDLE, WAIT_INIT, REQ, READ, CHECK, DONE} state_t;

  localparam logic [15:0] MAX_BLK    = 16'(MAX_BLOCKS);
  localparam logic [19:0] TIMER_LAST = TIMEOUT - 20'd1;

  state_t      state_reg, state_next;
  logic [9:0]  byte_cnt_reg, byte_cnt_next;
  logic        sig_ok_reg, sig_ok_next;
  logic [19:0] timer_reg, timer_next;
  logic [31:0] addr_reg, addr_next;
  logic        found_reg, found_next;
  logic        err_reg, err_next;
  logic [31:0] match_reg, match_next;
  logic [15:0] scanned_reg, scanned_next;

  logic [7:0]  sig_byte [8];
  logic        scan_active;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sig
      assign sig_byte[gi] = SIG[63-8*gi -: 8];
    end
  endgenerate

  assign scan_active = (state_reg != IDLE) && (state_reg != DONE);

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    sig_ok_next   = sig_ok_reg;
    timer_next    = timer_reg;
    addr_next     = addr_reg;
    found_next    = found_reg;
    err_next      = err_reg;
    match_next    = match_reg;
    scanned_next  = scanned_reg;

    // Abort freezes all bookkeeping except the result flags.
    if (abort && scan_active) begin
      state_next = IDLE;
      found_next = 1'b0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next   = WAIT_INIT;
            found_next   = 1'b0;
            err_next     = 1'b0;
            match_next   = 32'd0;
            scanned_next = 16'd0;
            addr_next    = BASE_ADDR;
          end
        end
        WAIT_INIT: begin
          if (init_finish) state_next = REQ;
        end
        REQ: begin
          byte_cnt_next = 10'd0;
          sig_ok_next   = 1'b1;
          timer_next    = 20'd0;
          state_next    = READ;
        end
        READ: begin
          if (byte_cnt_reg[9]) begin
            state_next   = CHECK;
            scanned_next = scanned_reg + 16'd1;
          end else if (out_valid) begin
            byte_cnt_next = byte_cnt_reg + 10'd1;
            timer_next    = 20'd0;
            if (byte_cnt_reg[9:3] == 7'd0 && dout != sig_byte[byte_cnt_reg[2:0]])
              sig_ok_next = 1'b0;
          end else if (timer_reg == TIMER_LAST) begin
            state_next = DONE;
            err_next   = 1'b1;
            found_next = 1'b0;
          end else begin
            timer_next = timer_reg + 20'd1;
          end
        end
        CHECK: begin
          if (sig_ok_reg) begin
            state_next = DONE;
            found_next = 1'b1;
            match_next = addr_reg;
          end else if (scanned_reg == MAX_BLK) begin
            state_next = DONE;
            found_next = 1'b0;
          end else begin
            addr_next  = addr_reg + 32'd1;
            state_next = REQ;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 10'd0;
      sig_ok_reg   <= 1'b0;
      timer_reg    <= 20'd0;
      addr_reg     <= BASE_ADDR;
      found_reg    <= 1'b0;
      err_reg      <= 1'b0;
      match_reg    <= 32'd0;
      scanned_reg  <= 16'd0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      sig_ok_reg   <= sig_ok_next;
      timer_reg    <= timer_next;
      addr_reg     <= addr_next;
      found_reg    <= found_next;
      err_reg      <= err_next;
      match_reg    <= match_next;
      scanned_reg  <= scanned_next;
    end
  end

  // The cycle spent at byte_cnt == 512 never writes, keeping buf_addr in 0..511.
  assign buf_we         = (state_reg == READ) && out_valid && !byte_cnt_reg[9];
  assign buf_addr       = byte_cnt_reg[8:0];
  assign buf_wdata      = dout;
  assign rd_req         = (state_reg == REQ);
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign block_address  = addr_reg;
  assign found          = found_reg;
  assign err            = err_reg;
  assign match_addr     = match_reg;
  assign blocks_scanned = scanned_reg;

endmodule

// File: tb/tb_sd_block_scanner.sv
// Randomized bench: two scanner instances (default base, and a base that wraps)
// served by an SD block model; results predicted from the block contents.
module tb_sd_block_scanner;

  localparam logic [63:0] SIG = 64'h444C41425F544142;
  localparam int          TO  = 100;

  logic        clk = 1'b0;
  logic        reset, abort, init_finish, out_valid;
  logic [7:0]  dout;
  logic [1:0]  start_v;
  logic [1:0]  rd_req_v, buf_we_v, busy_v, done_v, found_v, err_v;
  logic [31:0] block_address_o [2];
  logic [8:0]  buf_addr_o      [2];
  logic [7:0]  buf_wdata_o     [2];
  logic [31:0] match_addr_o    [2];
  logic [15:0] blocks_scanned_o[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sd_block_scanner #(
    .BASE_ADDR(32'd8192), .MAX_BLOCKS(4), .SIG(SIG), .TIMEOUT(20'd100)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort),
    .init_finish(init_finish), .rd_req(rd_req_v[0]),
    .block_address(block_address_o[0]), .dout(dout), .out_valid(out_valid),
    .buf_we(buf_we_v[0]), .buf_addr(buf_addr_o[0]), .buf_wdata(buf_wdata_o[0]),
    .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]), .err(err_v[0]),
    .match_addr(match_addr_o[0]), .blocks_scanned(blocks_scanned_o[0])
  );

  sd_block_scanner #(
    .BASE_ADDR(32'hFFFFFFFF), .MAX_BLOCKS(2), .SIG(SIG), .TIMEOUT(20'd100)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort),
    .init_finish(init_finish), .rd_req(rd_req_v[1]),
    .block_address(block_address_o[1]), .dout(dout), .out_valid(out_valid),
    .buf_we(buf_we_v[1]), .buf_addr(buf_addr_o[1]), .buf_wdata(buf_wdata_o[1]),
    .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]), .err(err_v[1]),
    .match_addr(match_addr_o[1]), .blocks_scanned(blocks_scanned_o[1])
  );

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'd8192 : 32'hFFFFFFFF;
  endfunction

  function automatic int maxb_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] sig_byte(input int i);
    logic [63:0] s;
    s = SIG;
    return s[63-8*i -: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete scan on instance k. sig_blk: index of the block carrying the
  // signature (-1 none). stall_*: SD stops after stall_at bytes of stall_blk.
  // cut_*: abort (or reset when cut_reset) before byte cut_at of cut_blk.
  task automatic run_scan(input int k, input int sig_blk, input int init_delay,
                          input int stall_blk, input int stall_at,
                          input int cut_blk, input int cut_at, input bit cut_reset,
                          input bit poke_start);
    logic [7:0]  blk [512];
    logic [31:0] exp_addr;
    int w, p;
    bit early, match, last;

    init_finish = (init_delay == 0);
    start_v[k]  = 1'b1;
    @(negedge clk);
    start_v[k]  = 1'b0;
    chk("busy_after_start", busy_v[k], 1);
    chk("cleared_on_start", {found_v[k], err_v[k], match_addr_o[k], blocks_scanned_o[k]}, 0);
    chk("addr_on_start", block_address_o[k], base_of(k));

    if (init_delay > 0) begin
      early = 0;
      repeat (init_delay) begin
        early |= rd_req_v[k] | ~busy_v[k];
        @(negedge clk);
      end
      chk("wait_init_hold", early, 0);
      init_finish = 1'b1;
    end

    for (int b = 0; b < maxb_of(k); b++) begin
      w = 0;
      while (!rd_req_v[k] && w < 8) begin @(negedge clk); w++; end
      chk("rd_req_seen", rd_req_v[k], 1);
      if (!rd_req_v[k]) return;
      if (init_delay > 0 && b == 0) chk("init_to_req_latency", w, 1);
      exp_addr = base_of(k) + 32'(b);
      chk("req_address", block_address_o[k], exp_addr);
      chk("blocks_so_far", blocks_scanned_o[k], b);
      @(negedge clk);
      chk("rd_req_one_cycle", rd_req_v[k], 0);

      for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
      if (b == sig_blk) begin
        for (int i = 0; i < 8; i++) blk[i] = sig_byte(i);
      end else if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) blk[i] = sig_byte(i);
        p = int'($urandom_range(0, 7));
        blk[p] ^= 8'($urandom_range(1, 255));
      end
      match = 1;
      for (int i = 0; i < 8; i++) if (blk[i] != sig_byte(i)) match = 0;

      for (int i = 0; i < 512; i++) begin
        start_v[k] = 1'b0;
        if (b == cut_blk && i == cut_at) begin
          if (cut_reset) begin
            reset = 1'b1; out_valid = 1'b1; dout = 8'($urandom);
          end else begin
            abort = 1'b1; out_valid = 1'b0;
          end
          @(negedge clk);
          chk("cut_to_idle", {busy_v[k], done_v[k], found_v[k], err_v[k], buf_we_v[k]}, 0);
          if (cut_reset)
            chk("reset_regs", {block_address_o[k], blocks_scanned_o[k]}, {base_of(k), 16'd0});
          reset = 1'b0; abort = 1'b0; out_valid = 1'b0;
          early = 0;
          repeat (4) begin @(negedge clk); early |= done_v[k] | busy_v[k]; end
          chk("no_done_after_cut", early, 0);
          $display("scan dut%0d: cut (%s) at block %0d byte %0d", k,
                   cut_reset ? "reset" : "abort", b, i);
          return;
        end
        if (b == stall_blk && i == stall_at) begin
          out_valid = 1'b0;
          early = 0;
          for (int j = 1; j <= TO; j++) begin
            #1;
            early |= done_v[k] | buf_we_v[k];
            @(negedge clk);
          end
          chk("timeout_not_early", early, 0);
          chk("timeout_done", done_v[k], 1);
          chk("timeout_flags", {err_v[k], found_v[k]}, 2'b10);
          chk("timeout_blocks", blocks_scanned_o[k], b);
          @(negedge clk);
          chk("timeout_done_one_cycle", {done_v[k], busy_v[k]}, 0);
          chk("timeout_err_held", err_v[k], 1);
          $display("scan dut%0d: timeout after %0d bytes of block %0d", k, i, b);
          return;
        end
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) begin
            out_valid = 1'b0;
            #1;
            chk("no_write_when_idle", buf_we_v[k], 0);
            @(negedge clk);
          end
        end
        out_valid = 1'b1;
        dout      = blk[i];
        if (poke_start && i == 100) start_v[k] = 1'b1;
        #1;
        chk("buf_write", {buf_we_v[k], buf_addr_o[k], buf_wdata_o[k]}, {1'b1, 9'(i), blk[i]});
        chk("other_dut_quiet", buf_we_v[1-k], 0);
        @(negedge clk);
      end
      out_valid  = 1'b0;
      start_v[k] = 1'b0;

      last = match || (b + 1 == maxb_of(k));
      w = 0;
      while (!(rd_req_v[k] || done_v[k]) && w < 8) begin @(negedge clk); w++; end
      chk("block_end_event", {done_v[k], rd_req_v[k]}, last ? 2'b10 : 2'b01);
      chk("block_end_latency", w, 2);
      if (last) begin
        chk("done_flags", {found_v[k], err_v[k]}, {match, 1'b0});
        chk("done_match_addr", match_addr_o[k], match ? exp_addr : 32'd0);
        chk("done_blocks", blocks_scanned_o[k], b + 1);
        chk("done_block_address", block_address_o[k], exp_addr);
        chk("busy_in_done", busy_v[k], 1);
        @(negedge clk);
        chk("done_one_cycle", {done_v[k], busy_v[k]}, 0);
        chk("result_held", {found_v[k], blocks_scanned_o[k]}, {match, 16'(b + 1)});
        $display("scan dut%0d: blocks=%0d found=%0b match_addr=0x%h", k, b + 1, match,
                 match_addr_o[k]);
        return;
      end
    end
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    reset = 1'b1; start_v = 2'b00; abort = 1'b0; init_finish = 1'b0;
    out_valid = 1'b0; dout = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_flags", {rd_req_v[k], busy_v[k], done_v[k], found_v[k], err_v[k], buf_we_v[k]}, 0);
      chk("reset_block_address", block_address_o[k], base_of(k));
      chk("reset_results", {match_addr_o[k], blocks_scanned_o[k]}, 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // SD bytes and abort arriving while idle must be ignored.
    out_valid = 1'b1; dout = 8'hA5; abort = 1'b1; quiet = 0;
    repeat (5) begin
      #1;
      quiet |= |buf_we_v | |busy_v | |done_v;
      @(negedge clk);
    end
    chk("idle_ignores_inputs", quiet, 0);
    out_valid = 1'b0; abort = 1'b0;

    run_scan(0,  2,  0, -1,  -1, -1,  -1, 0, 0);
    run_scan(0, -1,  0, -1,  -1, -1,  -1, 0, 0);
    run_scan(0,  1, 50, -1,  -1, -1,  -1, 0, 0);
    run_scan(0, -1,  0,  0, 200, -1,  -1, 0, 0);
    run_scan(0, -1,  0, -1,  -1,  1, 300, 0, 0);
    run_scan(0,  0,  0, -1,  -1, -1,  -1, 0, 0);
    run_scan(1, -1,  0, -1,  -1, -1,  -1, 0, 1);
    run_scan(1,  1,  0, -1,  -1, -1,  -1, 0, 1);
    run_scan(0,  3,  0, -1,  -1,  0, 100, 1, 0);
    for (int r = 0; r < 4; r++)
      run_scan(r % 2, int'($urandom_range(0, 4)) - 1, 0, -1, -1, -1, -1, 0, r[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
